// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encodings and frame constants for the 8N1 UART.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_START   = 3'd1,
        TX_DATA    = 3'd2,
        TX_STOP    = 3'd3,
        TX_CLEANUP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_t;

    localparam logic       START_BIT    = 1'b0;
    localparam logic       STOP_BIT     = 1'b1;
    localparam int         DATA_BITS    = 8;
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Brief    : Bit-period counter; ticks at the full-bit or half-bit terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_half_mode,
    output logic o_tick
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_terminal;

    assign w_terminal = i_half_mode ? HALF_CNT : FULL_CNT;
    assign o_tick     = i_run && (r_count == w_terminal);

    // The count restarts from zero on every tick so each period begins cleanly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_run || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_txrx.sv
`default_nettype none
// ============================================================================
// Module   : uart_txrx
// Brief    : Full-duplex 8N1 UART with independent TX and RX state machines.
// Revision : 1.0 - initial release
// ============================================================================
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_active,
    output logic       o_tx_serial,
    output logic       o_tx_done,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte
);

    tx_state_t  r_tx_state;
    logic [7:0] r_tx_data;
    logic [2:0] r_tx_idx;
    logic [2:0] w_tx_next_idx;
    logic       r_tx_serial;
    logic       r_tx_active;
    logic       r_tx_done;
    logic       w_tx_run;
    logic       w_tx_tick;

    assign w_tx_run      = (r_tx_state == TX_START) || (r_tx_state == TX_DATA) ||
                           (r_tx_state == TX_STOP);
    assign w_tx_next_idx = r_tx_idx + 3'd1;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (w_tx_run),
        .i_half_mode (1'b0),
        .o_tick      (w_tx_tick)
    );

    // Line level is registered on the state transition, so it changes on the tick edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_tx_data   <= '0;
            r_tx_idx    <= '0;
            r_tx_serial <= STOP_BIT;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_serial <= STOP_BIT;
                    r_tx_done   <= 1'b0;
                    r_tx_idx    <= '0;
                    if (i_tx_dv) begin
                        r_tx_data   <= i_tx_byte;
                        r_tx_active <= 1'b1;
                        r_tx_serial <= START_BIT;
                        r_tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx_serial <= r_tx_data[0];
                        r_tx_state  <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        if (r_tx_idx == LAST_BIT_IDX) begin
                            r_tx_serial <= STOP_BIT;
                            r_tx_state  <= TX_STOP;
                        end else begin
                            r_tx_idx    <= w_tx_next_idx;
                            r_tx_serial <= r_tx_data[w_tx_next_idx];
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_active <= 1'b0;
                        r_tx_done   <= 1'b1;
                        r_tx_state  <= TX_CLEANUP;
                    end
                end
                TX_CLEANUP: begin
                    r_tx_done  <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign o_tx_serial = r_tx_serial;
    assign o_tx_active = r_tx_active;
    assign o_tx_done   = r_tx_done;

    rx_state_t  r_rx_state;
    logic       r_rx_meta;
    logic       r_rx_sync;
    logic [7:0] r_rx_shift;
    logic [2:0] r_rx_idx;
    logic [7:0] r_rx_byte;
    logic       r_rx_dv;
    logic       w_rx_run;
    logic       w_rx_half;
    logic       w_rx_tick;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx_serial;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx_run  = (r_rx_state == RX_START) || (r_rx_state == RX_DATA) ||
                       (r_rx_state == RX_STOP);
    assign w_rx_half = (r_rx_state == RX_START);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (w_rx_run),
        .i_half_mode (w_rx_half),
        .o_tick      (w_rx_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_shift <= '0;
            r_rx_idx   <= '0;
            r_rx_byte  <= '0;
            r_rx_dv    <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_dv  <= 1'b0;
                    r_rx_idx <= '0;
                    if (r_rx_sync == START_BIT) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid start bit: a line that has returned high was only a glitch.
                    if (w_rx_tick) begin
                        r_rx_state <= (r_rx_sync == START_BIT) ? RX_DATA : RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_shift[r_rx_idx] <= r_rx_sync;
                        if (r_rx_idx == LAST_BIT_IDX) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        if (r_rx_sync == STOP_BIT) begin
                            r_rx_byte <= r_rx_shift;
                            r_rx_dv   <= 1'b1;
                        end
                        r_rx_state <= RX_CLEANUP;
                    end
                end
                RX_CLEANUP: begin
                    r_rx_dv    <= 1'b0;
                    r_rx_state <= RX_IDLE;
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign o_rx_dv   = r_rx_dv;
    assign o_rx_byte = r_rx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_txrx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_txrx
// Brief    : Directed loopback and external-RX bench for uart_txrx with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_txrx;

    localparam int CLKS_PER_BIT = 434;
    localparam int FRAME        = 10 * CLKS_PER_BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_active;
    logic       tx_serial;
    logic       tx_done;
    logic       rx_serial;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       loop_en = 1'b1;
    logic       ext_rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int rx_dv_count = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    assign rx_serial = loop_en ? tx_serial : ext_rx;

    uart_txrx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tx_dv     (tx_dv),
        .i_tx_byte   (tx_byte),
        .o_tx_active (tx_active),
        .o_tx_serial (tx_serial),
        .o_tx_done   (tx_done),
        .i_rx_serial (rx_serial),
        .o_rx_dv     (rx_dv),
        .o_rx_byte   (rx_byte)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every received byte must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_dv === 1'b1) begin
                rx_dv_count++;
                check("rx_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input int busy_at,
                              output int low_len, output logic [7:0] bits,
                              output logic stop_val, output int done_at,
                              output int done_cnt, output logic [7:0] rx_at_done,
                              output logic active0);
        bit low_run;
        low_len    = 0;
        bits       = '0;
        stop_val   = 1'b0;
        done_at    = -1;
        done_cnt   = 0;
        rx_at_done = '0;
        low_run    = 1'b1;
        @(negedge clk);
        tx_byte = b;
        tx_dv   = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        tx_dv   = 1'b0;
        active0 = tx_active;
        for (int i = 0; i < FRAME + 60; i++) begin
            if (i == busy_at) begin
                tx_byte = 8'h55;
                tx_dv   = 1'b1;
            end else if (i == busy_at + 1) begin
                tx_dv = 1'b0;
            end
            if (low_run && tx_serial === 1'b0) low_len++;
            else low_run = 1'b0;
            for (int j = 0; j < 8; j++) begin
                if (i == CLKS_PER_BIT * (j + 1) + CLKS_PER_BIT / 2) bits[j] = tx_serial;
            end
            if (i == 9 * CLKS_PER_BIT + CLKS_PER_BIT / 2) stop_val = tx_serial;
            if (tx_done === 1'b1) begin
                if (done_at < 0) begin
                    done_at    = i;
                    rx_at_done = rx_byte;
                end
                done_cnt++;
            end
            @(negedge clk);
        end
        tx_dv = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop, input int stop_len);
        ext_rx = 1'b0;
        repeat (CLKS_PER_BIT) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            ext_rx = b[j];
            repeat (CLKS_PER_BIT) @(negedge clk);
        end
        ext_rx = stop;
        repeat (stop_len) @(negedge clk);
        ext_rx = 1'b1;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    initial begin
        int         low_len;
        logic [7:0] bits;
        logic       stop_val;
        int         done_at;
        int         done_cnt;
        logic [7:0] rx_at_done;
        logic       active0;
        int         dv_before;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_serial", 32'(tx_serial), 32'd1);
        check("rst_tx_active", 32'(tx_active), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rx_dv", 32'(rx_dv), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Loopback 0xAB with full frame timing
        dv_before = rx_dv_count;
        send_frame(8'hAB, -1, low_len, bits, stop_val, done_at, done_cnt, rx_at_done, active0);
        check("ab_active", 32'(active0), 32'd1);
        check("ab_start_len", 32'(low_len), 32'(CLKS_PER_BIT));
        check("ab_bits", 32'(bits), 32'hAB);
        check("ab_stop", 32'(stop_val), 32'd1);
        check("ab_done_at", 32'(done_at), 32'(FRAME));
        check("ab_done_width", 32'(done_cnt), 32'd1);
        check("ab_rx_at_done", 32'(rx_at_done), 32'hAB);
        check("ab_dv_count", 32'(rx_dv_count - dv_before), 32'd1);
        check("ab_idle_after", 32'(tx_active), 32'd0);

        // Second loopback byte after a gap
        repeat (500) @(negedge clk);
        dv_before = rx_dv_count;
        send_frame(8'h3F, -1, low_len, bits, stop_val, done_at, done_cnt, rx_at_done, active0);
        check("3f_bits", 32'(bits), 32'h3F);
        check("3f_rx_at_done", 32'(rx_at_done), 32'h3F);
        check("3f_dv_count", 32'(rx_dv_count - dv_before), 32'd1);
        check("3f_done_at", 32'(done_at), 32'(FRAME));

        // Request while busy must be ignored
        repeat (50) @(negedge clk);
        dv_before = rx_dv_count;
        send_frame(8'hC6, 1000, low_len, bits, stop_val, done_at, done_cnt, rx_at_done, active0);
        check("busy_bits", 32'(bits), 32'hC6);
        check("busy_rx_at_done", 32'(rx_at_done), 32'hC6);
        check("busy_dv_count", 32'(rx_dv_count - dv_before), 32'd1);
        check("busy_no_queue", 32'(tx_active), 32'd0);

        // External RX: glitch, framing error, then a good frame
        loop_en = 1'b0;
        ext_rx  = 1'b1;
        repeat (20) @(negedge clk);
        dv_before = rx_dv_count;
        ext_rx = 1'b0;
        repeat (100) @(negedge clk);
        ext_rx = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_no_dv", 32'(rx_dv_count - dv_before), 32'd0);
        check("glitch_byte_held", 32'(rx_byte), 32'hC6);
        drive_rx(8'h96, 1'b0, 300);
        repeat (600) @(negedge clk);
        check("frame_err_no_dv", 32'(rx_dv_count - dv_before), 32'd0);
        check("frame_err_byte_held", 32'(rx_byte), 32'hC6);
        exp_q.push_back(8'h2D);
        drive_rx(8'h2D, 1'b1, CLKS_PER_BIT);
        check("ext_dv_count", 32'(rx_dv_count - dv_before), 32'd1);
        check("ext_byte", 32'(rx_byte), 32'h2D);

        // Reset mid-frame, then recover with 0x00
        loop_en = 1'b1;
        repeat (20) @(negedge clk);
        tx_byte = 8'h5A;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (2000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_serial", 32'(tx_serial), 32'd1);
        check("mid_rst_tx_active", 32'(tx_active), 32'd0);
        check("mid_rst_tx_done", 32'(tx_done), 32'd0);
        check("mid_rst_rx_dv", 32'(rx_dv), 32'd0);
        check("mid_rst_rx_byte", 32'(rx_byte), 32'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        dv_before = rx_dv_count;
        send_frame(8'h00, -1, low_len, bits, stop_val, done_at, done_cnt, rx_at_done, active0);
        check("zero_bits", 32'(bits), 32'h00);
        check("zero_rx_at_done", 32'(rx_at_done), 32'h00);
        check("zero_dv_count", 32'(rx_dv_count - dv_before), 32'd1);
        check("zero_done_at", 32'(done_at), 32'(FRAME));

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
